// File: rtl/bomberman_pkg.sv
// Shared tile codes, blast directions and map geometry for the bomberman datapath.
package bomberman_pkg;

  localparam int unsigned MAP_NUM_ROW = 11;
  localparam int unsigned MAP_NUM_COL = 19;

  typedef enum logic [3:0] {
    TILE_EMPTY = 4'd0,
    TILE_HARD  = 4'd1,
    TILE_SOFT  = 4'd2,
    TILE_BOMB  = 4'd3,
    TILE_FLAME = 4'd4
  } tile_t;

  typedef enum logic [2:0] {
    CENTER,
    UP,
    DOWN,
    LEFT,
    RIGHT
  } dir_t;

  // Row step for one tile of travel in direction d.
  function automatic int dir_drow(dir_t d);
    case (d)
      UP:      return -1;
      DOWN:    return 1;
      default: return 0;
    endcase
  endfunction

  // Column step for one tile of travel in direction d.
  function automatic int dir_dcol(dir_t d);
    case (d)
      LEFT:    return -1;
      RIGHT:   return 1;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/bomb_controller_if.sv
// Map memory access bundle: second synchronous read port plus the write port.
interface bomb_controller_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W-1:0] map_rd_addr;
  logic [3:0]        map_rd_data;
  logic              map_we;
  logic [ADDR_W-1:0] map_wr_addr;
  logic [3:0]        map_wr_data;

  modport master (
    output map_rd_addr,
    output map_we,
    output map_wr_addr,
    output map_wr_data,
    input  map_rd_data
  );

  modport slave (
    input  map_rd_addr,
    input  map_we,
    input  map_wr_addr,
    input  map_wr_data,
    output map_rd_data
  );
endinterface

// File: rtl/bomb_controller_tick_counter.sv
// Loadable down-counter stepped by the frame tick; saturates at zero.
module bomb_controller_tick_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_tick,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Load has priority over a coincident tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_tick && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/bomb_controller.sv
// Single-bomb lifecycle: place, fuse, blast walk, flame hold, clear walk.
module bomb_controller
  import bomberman_pkg::*;
#(
  parameter int unsigned NUM_ROW     = MAP_NUM_ROW,
  parameter int unsigned NUM_COL     = MAP_NUM_COL,
  parameter int unsigned RANGE       = 2,
  parameter int unsigned FUSE_TICKS  = 180,
  parameter int unsigned FLAME_TICKS = 30,
  localparam int unsigned ROW_W      = $clog2(NUM_ROW),
  localparam int unsigned COL_W      = $clog2(NUM_COL)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick,
  input  logic             i_place_bomb,
  input  logic [ROW_W-1:0] i_player_row,
  input  logic [COL_W-1:0] i_player_col,
  bomb_controller_if.master map,
  output logic             o_bomb_active,
  output logic             o_flame_active,
  output logic [ROW_W-1:0] o_bomb_row,
  output logic [COL_W-1:0] o_bomb_col
);

  localparam int unsigned ADDR_W   = $clog2(NUM_ROW * NUM_COL);
  localparam int unsigned MAX_TICK = (FUSE_TICKS > FLAME_TICKS) ? FUSE_TICKS : FLAME_TICKS;
  localparam int unsigned CNT_W    = $clog2(MAX_TICK + 1);

  typedef enum logic [2:0] {
    StIdle, StPlace, StFuse, StRd, StWait, StEval, StFlame
  } state_e;

  state_e           r_state, w_state_d;
  logic [ROW_W-1:0] r_row, w_row_d;
  logic [COL_W-1:0] r_col, w_col_d;
  dir_t             r_dir, w_dir_d;
  logic [2:0]       r_k, w_k_d;
  logic             r_clear, w_clear_d;   // walk is the CLEAR pass, not BLAST
  logic             r_place_q;

  logic             w_press, w_adv, w_cnt_load, w_cnt_zero;
  logic [CNT_W-1:0] w_cnt_val;
  int               w_tgt_row, w_tgt_col;
  logic             w_on_map;
  logic [ADDR_W-1:0] w_tgt_addr, w_bomb_addr;
  logic             w_we;
  logic [ADDR_W-1:0] w_wr_addr, w_rd_addr;
  logic [3:0]       w_wr_data;

  assign w_press = i_place_bomb & ~r_place_q;

  bomb_controller_tick_counter #(
    .CNT_W(CNT_W)
  ) u_tick_counter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_tick     (i_tick),
    .o_zero     (w_cnt_zero)
  );

  // Target tile of the walk, in signed coordinates so off-map is detectable.
  always_comb begin
    w_tgt_row   = int'(r_row) + dir_drow(r_dir) * int'(r_k);
    w_tgt_col   = int'(r_col) + dir_dcol(r_dir) * int'(r_k);
    w_on_map    = (w_tgt_row >= 0) && (w_tgt_row < int'(NUM_ROW)) &&
                  (w_tgt_col >= 0) && (w_tgt_col < int'(NUM_COL));
    w_tgt_addr  = ADDR_W'(w_tgt_row * int'(NUM_COL) + w_tgt_col);
    w_bomb_addr = ADDR_W'(int'(r_row) * int'(NUM_COL) + int'(r_col));
  end

  // Next-state, counter control and map port drive.
  always_comb begin
    w_state_d  = r_state;
    w_row_d    = r_row;
    w_col_d    = r_col;
    w_dir_d    = r_dir;
    w_k_d      = r_k;
    w_clear_d  = r_clear;
    w_adv      = 1'b0;
    w_cnt_load = 1'b0;
    w_cnt_val  = '0;
    w_we       = 1'b0;
    w_wr_addr  = '0;
    w_wr_data  = TILE_EMPTY;
    w_rd_addr  = '0;

    unique case (r_state)
      StIdle: begin
        if (w_press) begin
          w_row_d   = i_player_row;
          w_col_d   = i_player_col;
          w_state_d = StPlace;
        end
      end
      StPlace: begin
        w_we       = 1'b1;
        w_wr_addr  = w_bomb_addr;
        w_wr_data  = TILE_BOMB;
        w_cnt_load = 1'b1;
        w_cnt_val  = CNT_W'(FUSE_TICKS);
        w_state_d  = StFuse;
      end
      StFuse: begin
        if (i_tick && w_cnt_zero) begin
          w_state_d = StRd;
          w_dir_d   = CENTER;
          w_k_d     = '0;
          w_clear_d = 1'b0;
        end
      end
      StRd: begin
        if (r_dir == CENTER) begin
          w_we      = 1'b1;
          w_wr_addr = w_bomb_addr;
          w_wr_data = r_clear ? TILE_EMPTY : TILE_FLAME;
          w_adv     = 1'b1;
        end else if (!w_on_map) begin
          w_adv = 1'b1;
        end else begin
          w_rd_addr = w_tgt_addr;
          w_state_d = StWait;
        end
      end
      StWait: begin
        // Hold the address so the read data is still valid in EVAL.
        w_rd_addr = w_tgt_addr;
        w_state_d = StEval;
      end
      StEval: begin
        w_wr_addr = w_tgt_addr;
        if (!r_clear) begin
          w_wr_data = TILE_FLAME;
          if (map.map_rd_data == TILE_HARD) begin
            w_adv = 1'b1;
          end else if (map.map_rd_data == TILE_SOFT) begin
            w_we  = 1'b1;
            w_adv = 1'b1;
          end else begin
            w_we = 1'b1;
            if (r_k == 3'(RANGE)) w_adv = 1'b1;
            else begin
              w_k_d     = r_k + 3'd1;
              w_state_d = StRd;
            end
          end
        end else begin
          w_wr_data = TILE_EMPTY;
          if (map.map_rd_data == TILE_FLAME) begin
            w_we = 1'b1;
            if (r_k == 3'(RANGE)) w_adv = 1'b1;
            else begin
              w_k_d     = r_k + 3'd1;
              w_state_d = StRd;
            end
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      StFlame: begin
        if (i_tick && w_cnt_zero) begin
          w_state_d = StRd;
          w_dir_d   = CENTER;
          w_k_d     = '0;
          w_clear_d = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase

    // Move to the next direction, or leave the walk after RIGHT.
    if (w_adv) begin
      if (r_dir == RIGHT) begin
        if (r_clear) begin
          w_state_d = StIdle;
        end else begin
          w_state_d  = StFlame;
          w_cnt_load = 1'b1;
          w_cnt_val  = CNT_W'(FLAME_TICKS);
        end
      end else begin
        w_dir_d   = dir_t'(r_dir + 3'd1);
        w_k_d     = 3'd1;
        w_state_d = StRd;
      end
    end
  end

  // State and walk registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_row     <= '0;
      r_col     <= '0;
      r_dir     <= CENTER;
      r_k       <= '0;
      r_clear   <= 1'b0;
      r_place_q <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_row     <= w_row_d;
      r_col     <= w_col_d;
      r_dir     <= w_dir_d;
      r_k       <= w_k_d;
      r_clear   <= w_clear_d;
      r_place_q <= i_place_bomb;
    end
  end

  assign map.map_we      = w_we;
  assign map.map_wr_addr = w_wr_addr;
  assign map.map_wr_data = w_wr_data;
  assign map.map_rd_addr = w_rd_addr;

  assign o_bomb_active  = (r_state == StPlace) || (r_state == StFuse);
  assign o_flame_active = (r_state == StRd) || (r_state == StWait) ||
                          (r_state == StEval) || (r_state == StFlame);
  assign o_bomb_row     = r_row;
  assign o_bomb_col     = r_col;

endmodule

// File: tb/tb_bomb_controller.sv
// Bench for bomb_controller: map memory model, write monitor and a tile-level reference model.
module tb_bomb_controller;
  import bomberman_pkg::*;

  localparam int NR      = 11;
  localparam int NC      = 19;
  localparam int RNG     = 2;
  localparam int FUSE_T  = 3;
  localparam int FLAME_T = 2;
  localparam int AW      = 8;
  localparam int NT      = NR * NC;

  logic       clk = 1'b0;
  logic       rst_n, tick, place, mem_load;
  logic [3:0] prow, brow;
  logic [4:0] pcol, bcol;
  logic       bomb_act, flame_act;

  always #5 clk = ~clk;

  bomb_controller_if #(.ADDR_W(AW)) mif ();

  bomb_controller #(
    .NUM_ROW     (NR),
    .NUM_COL     (NC),
    .RANGE       (RNG),
    .FUSE_TICKS  (FUSE_T),
    .FLAME_TICKS (FLAME_T)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_tick         (tick),
    .i_place_bomb   (place),
    .i_player_row   (prow),
    .i_player_col   (pcol),
    .map            (mif),
    .o_bomb_active  (bomb_act),
    .o_flame_active (flame_act),
    .o_bomb_row     (brow),
    .o_bomb_col     (bcol)
  );

  // map_mem stand-in: synchronous read, write strobe, bulk load from the bench.
  logic [3:0] mem      [NT];
  logic [3:0] init_map [NT];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < NT; i++) mem[i] <= init_map[i];
    end else if (mif.map_we) begin
      mem[mif.map_wr_addr] <= mif.map_wr_data;
    end
    mif.map_rd_data <= mem[mif.map_rd_addr];
  end

  // Every write the DUT issues, as addr*16 + data.
  int wq[$];
  always @(posedge clk) begin
    if (mif.map_we) wq.push_back(int'(mif.map_wr_addr) * 16 + int'(mif.map_wr_data));
  end

  int n_checks = 0;
  int n_fail   = 0;
  int model_map[NT];
  int exp_q[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int a_of(input int r, input int c);
    return r * NC + c;
  endfunction

  // Reference: walk the cross on the tile map and list the writes it implies.
  function automatic void model_walk(input int r0, input int c0, input bit clr);
    int dr[5] = '{0, -1, 1, 0, 0};
    int dc[5] = '{0, 0, 0, -1, 1};
    int r, c, a, t;
    exp_q.delete();
    a = a_of(r0, c0);
    model_map[a] = clr ? 0 : 4;
    exp_q.push_back(a * 16 + model_map[a]);
    for (int d = 1; d < 5; d++) begin
      for (int k = 1; k <= RNG; k++) begin
        r = r0 + dr[d] * k;
        c = c0 + dc[d] * k;
        if (r < 0 || r >= NR || c < 0 || c >= NC) break;
        a = a_of(r, c);
        t = model_map[a];
        if (!clr) begin
          if (t == 1) break;
          model_map[a] = 4;
          exp_q.push_back(a * 16 + 4);
          if (t == 2) break;
        end else begin
          if (t != 4) break;
          model_map[a] = 0;
          exp_q.push_back(a * 16);
        end
      end
    end
  endfunction

  task automatic compare_writes(input string tag, input int base);
    int got;
    check({tag, "_count"}, wq.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base + i < wq.size()) ? wq[base + i] : -1;
      check($sformatf("%s_wr%0d", tag, i), got, exp_q[i]);
    end
  endtask

  task automatic check_map(input string tag);
    int nd = 0;
    for (int i = 0; i < NT; i++) if (int'(mem[i]) != model_map[i]) nd++;
    check({tag, "_map_diffs"}, nd, 0);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic load_map();
    for (int i = 0; i < NT; i++) init_map[i] = 4'(model_map[i]);
    mem_load = 1'b1;
    @(negedge clk);
    mem_load = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NT; i++) model_map[i] = 0;
  endtask

  task automatic press_and_place(input int r, input int c, input bit hold, output bit ok);
    int base = wq.size();
    int n = 0;
    ok   = 1'b0;
    prow = 4'(r);
    pcol = 5'(c);
    place = 1'b1;
    @(negedge clk);
    if (!hold) place = 1'b0;
    while (wq.size() == base && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (wq.size() == base) begin
      check("place_timeout", 0, 1);
      return;
    end
    check("place_wr", wq[base], a_of(r, c) * 16 + 3);
    check("place_bomb_act", int'(bomb_act), 1);
    check("place_row", int'(brow), r);
    check("place_col", int'(bcol), c);
    model_map[a_of(r, c)] = 3;
    ok = 1'b1;
  endtask

  // Full lifecycle; with hold the button stays high and re-toggles mid-fuse.
  task automatic run_bomb(input int r, input int c, input bit hold);
    bit ok;
    int base;
    press_and_place(r, c, hold, ok);
    if (!ok) return;
    base = wq.size();
    for (int i = 0; i < FUSE_T; i++) begin
      pulse_tick();
      if (hold && i == 0) begin
        place = 1'b0;
        @(negedge clk);
        place = 1'b1;
        @(negedge clk);
      end
    end
    check("fuse_quiet", wq.size() - base, 0);
    check("fuse_bomb_act", int'(bomb_act), 1);
    pulse_tick();
    repeat (40) @(negedge clk);
    model_walk(r, c, 1'b0);
    compare_writes("blast", base);
    check("flame_act_on", int'(flame_act), 1);
    check("bomb_act_off", int'(bomb_act), 0);
    base = wq.size();
    for (int i = 0; i < FLAME_T; i++) pulse_tick();
    check("flame_quiet", wq.size() - base, 0);
    pulse_tick();
    repeat (40) @(negedge clk);
    model_walk(r, c, 1'b1);
    compare_writes("clear", base);
    check("flame_act_off", int'(flame_act), 0);
    check_map("after_clear");
    if (hold) begin
      base = wq.size();
      repeat (5) @(negedge clk);
      check("held_idle", wq.size() - base, 0);
      place = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit ok;
    int base, t;
    rst_n = 1'b0; tick = 1'b0; place = 1'b0; prow = '0; pcol = '0; mem_load = 1'b0;
    clear_model();
    load_map();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_bomb_act", int'(bomb_act), 0);
    check("rst_flame_act", int'(flame_act), 0);
    check("rst_row", int'(brow), 0);
    check("rst_col", int'(bcol), 0);
    check("rst_we", int'(mif.map_we), 0);

    // Open cross.
    clear_model(); load_map();
    run_bomb(5, 9, 1'b0);

    // Hard above, soft to the right.
    clear_model();
    model_map[a_of(4, 9)]  = 1;
    model_map[a_of(5, 10)] = 2;
    load_map();
    run_bomb(5, 9, 1'b0);
    check("obs_106", int'(mem[106]), 0);
    check("obs_105", int'(mem[105]), 0);

    // Corner.
    clear_model(); load_map();
    run_bomb(0, 0, 1'b0);

    // Reset during the fuse, then a fresh press.
    clear_model(); load_map();
    press_and_place(3, 4, 1'b0, ok);
    pulse_tick();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_bomb_act", int'(bomb_act), 0);
    check("midrst_flame_act", int'(flame_act), 0);
    check("midrst_row", int'(brow), 0);
    base = wq.size();
    for (int i = 0; i < FUSE_T + 2; i++) pulse_tick();
    check("midrst_no_wr", wq.size() - base, 0);
    run_bomb(3, 4, 1'b0);

    // Held button, extra edge during the fuse.
    clear_model(); load_map();
    run_bomb(7, 3, 1'b1);
    run_bomb(7, 4, 1'b0);

    // Random maps and positions.
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < NT; i++) begin
        t = int'($urandom_range(0, 9));
        model_map[i] = (t < 5) ? 0 : t - 5;
      end
      load_map();
      run_bomb(int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NC - 1)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
